// File: rtl/dmac_arb_pkg.sv
// Shared types and helpers for the DMAC AXI read arbiter: FSM states,
// the requester-count ceiling and a one-hot to index converter.
package dmac_arb_pkg;

  localparam int N_MASTER_MAX = 8;
  localparam int IDX_W        = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_MASTER_MAX-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MASTER_MAX; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational rotating picker: first asserted request at or after ptr
// (wrapping at N) wins and is returned one-hot.
module dmac_rr_picker
  import dmac_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // k is the search distance from ptr; the nearest requester wins
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
  end

endmodule

// File: rtl/dmac_axi_rd_arbiter.sv
// One-burst-at-a-time AXI read arbiter for DMAC channel engines.
// Define DMAC_RD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module dmac_axi_rd_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int N_MASTER   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MASTER-1:0]          m_arvalid,
  output logic [N_MASTER-1:0]          m_arready,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] m_araddr,
  input  logic [N_MASTER*ID_WIDTH-1:0] m_arid,
  input  logic [N_MASTER*4-1:0]        m_arlen,
  output logic [N_MASTER-1:0]          m_rvalid,
  input  logic [N_MASTER-1:0]          m_rready,
  output logic [DATA_WIDTH-1:0]        m_rdata,
  output logic [ID_WIDTH-1:0]          m_rid,
  output logic [1:0]                   m_rresp,
  output logic                         m_rlast,
  output logic                         s_arvalid,
  input  logic                         s_arready,
  output logic [ADDR_WIDTH-1:0]        s_araddr,
  output logic [ID_WIDTH-1:0]          s_arid,
  output logic [3:0]                   s_arlen,
  input  logic                         s_rvalid,
  output logic                         s_rready,
  input  logic [DATA_WIDTH-1:0]        s_rdata,
  input  logic [ID_WIDTH-1:0]          s_rid,
  input  logic [1:0]                   s_rresp,
  input  logic                         s_rlast,
  output logic [N_MASTER-1:0]          grant_o
);

  state_t                  state, state_nxt;
  logic [N_MASTER-1:0]     grant, grant_nxt, win;
  logic [N_MASTER_MAX-1:0] grant_pad;
  logic [IDX_W-1:0]        g_idx, ptr;
  logic                    ar_fire, r_fire, burst_done;

  always_comb begin
    grant_pad                 = '0;
    grant_pad[N_MASTER-1:0]   = grant;
  end
  assign g_idx = onehot2idx(grant_pad);

  dmac_rr_picker #(.N(N_MASTER)) u_picker (
    .req (m_arvalid),
    .ptr (ptr),
    .gnt (win)
  );

  assign ar_fire    = s_arvalid & s_arready;
  assign r_fire     = s_rvalid & s_rready;
  assign burst_done = (state == S_DATA) && r_fire && s_rlast;

`ifdef DMAC_RD_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;
  // Pointer moves past the owner only once its burst has fully drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rr_ptr <= '0;
    else if (burst_done) rr_ptr <= (g_idx == IDX_W'(N_MASTER-1)) ? '0 : g_idx + 1'b1;
  end
  assign ptr = rr_ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      S_IDLE: if (|m_arvalid) begin
        state_nxt = S_ADDR;
        grant_nxt = win;
      end
      S_ADDR: if (ar_fire) state_nxt = S_DATA;
      S_DATA: if (burst_done) begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Only the owner's channel is connected; everything else idles at zero,
  // which also keeps all outputs low while reset holds state in IDLE.
  always_comb begin
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (grant[i] && state == S_ADDR) begin
        s_arvalid    = m_arvalid[i];
        s_araddr     = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_arid       = m_arid[i*ID_WIDTH +: ID_WIDTH];
        s_arlen      = m_arlen[i*4 +: 4];
        m_arready[i] = s_arready;
      end
      if (grant[i] && state == S_DATA) begin
        m_rvalid[i] = s_rvalid;
        s_rready    = m_rready[i];
      end
    end
  end

  assign m_rdata = (state == S_DATA) ? s_rdata : '0;
  assign m_rid   = (state == S_DATA) ? s_rid   : '0;
  assign m_rresp = (state == S_DATA) ? s_rresp : '0;
  assign m_rlast = (state == S_DATA) ? s_rlast : 1'b0;
  assign grant_o = grant;

  a_arvalid_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_ADDR) |-> |(m_arvalid & grant))
    else $error("granted master dropped m_arvalid before AR handshake");

endmodule
